// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - MEM stage request/response bundle for the SRAM controller
interface sram_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - 32-bit word access as two timed 16-bit halves on an async SRAM
module sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  sram_ctrl_if.slave  mem,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          op_wr;
  logic [16:0]   word;
  logic [31:0]   wdata;
  logic [15:0]   rdata_lo;
  logic [16:0]   word_in;
  logic          start, last, access, drive;

  // Out-of-range addresses wrap silently through the truncation.
  assign word_in = 17'((mem.address - BASE_ADDR) >> 2);
  assign start   = (state == IDLE) & (mem.wr_en | mem.rd_en);
  assign last    = (cnt == LAST);
  assign access  = (state == LOW) | (state == HIGH);
  assign drive   = access & op_wr;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (start) begin
        state_nx = LOW;
        cnt_nx   = '0;
      end
      LOW: if (last) begin
        state_nx = HIGH;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
      HIGH: if (last) begin
        state_nx = DONE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      op_wr         <= 1'b0;
      word          <= '0;
      wdata         <= '0;
      rdata_lo      <= '0;
      mem.read_data <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (start) begin
        op_wr <= mem.wr_en;
        word  <= word_in;
        wdata <= mem.write_data;
      end
      if (state == LOW && last && !op_wr)
        rdata_lo <= SRAM_DQ;
      // read_data only moves when the high half lands, so it is stable from DONE on.
      if (state == HIGH && last && !op_wr)
        mem.read_data <= {SRAM_DQ, rdata_lo};
    end
  end

  assign SRAM_ADDR = access ? {word, (state == HIGH)} : 18'd0;
  assign SRAM_WE_N = ~drive;
  assign SRAM_DQ   = drive ? ((state == HIGH) ? wdata[31:16] : wdata[15:0]) : 16'hzzzz;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_UB_N = 1'b0;

  assign mem.ready = (state == DONE) | ((state == IDLE) & ~mem.wr_en & ~mem.rd_en);
endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - scoreboard bench: per-cycle expected bus records checked by monitors
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_ctrl_if if0 ();
  sram_ctrl_if if1 ();

  wire  [15:0] dq0, dq1;
  logic [17:0] addr0, addr1;
  logic        we0, oe0, ce0, lb0, ub0;
  logic        we1, oe1, ce1, lb1, ub1;

  sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .mem(if0.slave), .SRAM_DQ(dq0), .SRAM_ADDR(addr0),
    .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0), .SRAM_LB_N(lb0), .SRAM_UB_N(ub0));

  sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .mem(if1.slave), .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
    .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1), .SRAM_LB_N(lb1), .SRAM_UB_N(ub1));

  // Released bus reads as all ones through the pullups.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (dq0[i]);
    pullup (dq1[i]);
  end

  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];
  logic        model_en0 = 1'b0;
  logic        model_en1 = 1'b0;

  always @(posedge clk) if (!we0) mem0[addr0[7:0]] <= dq0;
  always @(posedge clk) if (!we1) mem1[addr1[7:0]] <= dq1;
  assign dq0 = (model_en0 && we0) ? mem0[addr0[7:0]] : 16'hzzzz;
  assign dq1 = (model_en1 && we1) ? mem1[addr1[7:0]] : 16'hzzzz;

  typedef struct {
    logic        rdy;
    logic        we_n;
    logic [17:0] addr;
    logic [15:0] dq;
    bit          chk_dq;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic rdy, input logic we_n, input logic [17:0] addr,
                              input logic [15:0] dq, input bit chk_dq, input logic [31:0] rdata,
                              input string name);
    exp_t e;
    e.rdy = rdy; e.we_n = we_n; e.addr = addr; e.dq = dq;
    e.chk_dq = chk_dq; e.rdata = rdata; e.name = name;
    return e;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h exp %h", nm, fld, got, exp);
    end
  endtask

  task automatic check(input exp_t e, input logic rdy, input logic we_n, input logic [17:0] a,
                       input logic [15:0] dq, input logic [31:0] rdat);
    cmp(e.name, "ready", {31'd0, rdy}, {31'd0, e.rdy});
    cmp(e.name, "we_n", {31'd0, we_n}, {31'd0, e.we_n});
    cmp(e.name, "addr", {14'd0, a}, {14'd0, e.addr});
    if (e.chk_dq) cmp(e.name, "dq", {16'd0, dq}, {16'd0, e.dq});
    cmp(e.name, "read_data", rdat, e.rdata);
  endtask

  always @(negedge clk) if (q0.size() != 0) check(q0.pop_front(), if0.ready, we0, addr0, dq0, if0.read_data);
  always @(negedge clk) if (q1.size() != 0) check(q1.pop_front(), if1.ready, we1, addr1, dq1, if1.read_data);

  task automatic push(input bit u, input exp_t e);
    if (u) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  // Expected records for a whole access: request cycle, W low, W high, DONE.
  task automatic push_xact(input bit u, input int w, input bit wr, input logic [17:0] lo,
                           input logic [31:0] d, input logic [31:0] rd0, input logic [31:0] rd1,
                           input string nm);
    push(u, mk(1'b0, 1'b1, 18'd0, 16'hFFFF, wr, rd0, {nm, ".req"}));
    for (int i = 0; i < w; i++) push(u, mk(1'b0, ~wr, lo, d[15:0], wr, rd0, {nm, ".low"}));
    for (int i = 0; i < w; i++) push(u, mk(1'b0, ~wr, lo | 18'd1, d[31:16], wr, rd0, {nm, ".high"}));
    push(u, mk(1'b1, 1'b1, 18'd0, 16'hFFFF, wr, rd1, {nm, ".done"}));
  endtask

  task automatic drive(input bit u, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d);
    if (u) begin
      if1.wr_en = wr; if1.rd_en = rd; if1.address = a; if1.write_data = d; model_en1 = rd & ~wr;
    end else begin
      if0.wr_en = wr; if0.rd_en = rd; if0.address = a; if0.write_data = d; model_en0 = rd & ~wr;
    end
  endtask

  task automatic xact(input bit u, input int w, input bit wr, input bit rd, input logic [31:0] a,
                      input logic [17:0] lo, input logic [31:0] d, input logic [31:0] rd0,
                      input logic [31:0] rd1, input string nm);
    push_xact(u, w, wr, lo, d, rd0, rd1, nm);
    drive(u, wr, rd, a, d);
    repeat (2 * w + 2) @(posedge clk);
    #1;
    drive(u, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic idle(input bit u, input int n, input logic [31:0] rdata, input string nm);
    for (int i = 0; i < n; i++) push(u, mk(1'b1, 1'b1, 18'd0, 16'hFFFF, 1'b1, rdata, nm));
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    mem1[0] = 16'h1111; mem1[1] = 16'h2222; mem1[2] = 16'h3333; mem1[3] = 16'h4444;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    idle(1'b0, 10, 32'h0, "t1.idle");

    xact(1'b0, 2, 1'b1, 1'b0, 32'h0000_0404, 18'd2, 32'hDEADBEEF, 32'h0, 32'h0, "t2.wr404");

    xact(1'b0, 2, 1'b0, 1'b1, 32'h0000_0404, 18'd2, 32'h0, 32'h0, 32'hDEADBEEF, "t3.rd404");
    xact(1'b0, 2, 1'b1, 1'b0, 32'h0000_0408, 18'd4, 32'hCAFEF00D, 32'hDEADBEEF, 32'hDEADBEEF, "t3.wr408");
    idle(1'b0, 2, 32'hDEADBEEF, "t3.hold");

    xact(1'b0, 2, 1'b1, 1'b1, 32'h0000_0400, 18'd0, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, "t4.both");
    xact(1'b0, 2, 1'b0, 1'b1, 32'h0000_0400, 18'd0, 32'h0, 32'hDEADBEEF, 32'h12345678, "t4.rd400");
    xact(1'b0, 2, 1'b0, 1'b1, 32'h0000_0408, 18'd4, 32'h0, 32'h12345678, 32'hCAFEF00D, "t4.rd408");

    // Reset lands in cycle 3 of a write, i.e. the first high-half cycle.
    push(1'b0, mk(1'b0, 1'b1, 18'd0, 16'hFFFF, 1'b1, 32'hCAFEF00D, "t5.req"));
    push(1'b0, mk(1'b0, 1'b0, 18'd2, 16'hF00D, 1'b1, 32'hCAFEF00D, "t5.low"));
    push(1'b0, mk(1'b0, 1'b0, 18'd2, 16'hF00D, 1'b1, 32'hCAFEF00D, "t5.low"));
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0404, 32'h0BADF00D);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    push(1'b0, mk(1'b0, 1'b1, 18'd0, 16'hFFFF, 1'b1, 32'h0, "t5.rst"));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1'b0, 3, 32'h0, "t5.after");

    xact(1'b1, 1, 1'b0, 1'b1, 32'h0000_0400, 18'd0, 32'h0, 32'h0, 32'h22221111, "t6.rd400");
    xact(1'b1, 1, 1'b0, 1'b1, 32'h0000_0404, 18'd2, 32'h0, 32'h22221111, 32'h44443333, "t6.rd404");
    idle(1'b1, 2, 32'h44443333, "t6.hold");

    cmp("end", "q0_left", q0.size(), 32'd0);
    cmp("end", "q1_left", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
